// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and its detector-side logic.
package seq_gen_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned REP_W     = 4;
  localparam int unsigned STATE_W   = 3;

  localparam logic [STATE_W-1:0] ST_CODE_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_CODE_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_CODE_SEND = 3'd2;
  localparam logic [STATE_W-1:0] ST_CODE_DONE = 3'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = ST_CODE_IDLE,
    ST_LOAD = ST_CODE_LOAD,
    ST_SEND = ST_CODE_SEND,
    ST_DONE = ST_CODE_DONE
  } state_t;

endpackage

// File: rtl/bit_period_timer.sv
// Loadable down-counter; tick_c marks the last cycle of every max(period,1)-cycle window.
module bit_period_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick_c
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;

  // Counter reloads itself at zero so consecutive windows abut with no gap.
  always_ff @(posedge clk) begin
    if (clr) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= (period == '0) ? DIV_W'(1) : period;
      cnt_q    <= (period == '0) ? '0 : period - DIV_W'(1);
    end else if (en) begin
      if (cnt_q == '0) cnt_q <= period_q - DIV_W'(1);
      else             cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick_c = en && (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends the low `length` bits MSB-first, repeated, at a divided bit rate.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [$clog2(PAT_W):0] length,
  input  logic [REP_W-1:0]       repeat_cnt,
  input  logic [DIV_W-1:0]       div,
  output logic                   bit_out,
  output logic                   bit_strobe,
  output logic                   busy,
  output logic                   done,
  output logic [STATE_W-1:0]     prsnt_state
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PAT_W-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]   bits_q, bits_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic               bit_out_q, bit_out_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               new_bit;
  logic               tick_c;

  bit_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .load   (state_q == ST_LOAD),
    .en     (state_q == ST_SEND),
    .period (div_q),
    .tick_c (tick_c)
  );

  // State, captured request, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      div_q     <= '0;
      shreg_q   <= '0;
      bits_q    <= '0;
      reps_q    <= '0;
      bit_out_q <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      div_q     <= div_d;
      shreg_q   <= shreg_d;
      bits_q    <= bits_d;
      reps_q    <= reps_d;
      bit_out_q <= bit_out_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath update, and output values for the coming cycle.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    div_d   = div_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    reps_d  = reps_q;
    new_bit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pat_d   = pattern;
          len_d   = (length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : length;
          rep_d   = repeat_cnt;
          div_d   = (div == '0) ? DIV_W'(1) : div;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Left-justify so the current bit always sits in the shift register MSB.
        shreg_d = pat_q << (LEN_W'(PAT_W) - len_q);
        bits_d  = len_q;
        reps_d  = rep_q;
        new_bit = 1'b1;
        state_d = (len_q == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (tick_c) begin
          if (bits_q > LEN_W'(1)) begin
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
            bits_d  = bits_q - LEN_W'(1);
            new_bit = 1'b1;
          end else if (reps_q != '0) begin
            shreg_d = pat_q << (LEN_W'(PAT_W) - len_q);
            bits_d  = len_q;
            reps_d  = reps_q - REP_W'(1);
            new_bit = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;

    bit_out_d = (state_d == ST_SEND) && shreg_d[PAT_W-1];
    strobe_d  = (state_d == ST_SEND) && new_bit;
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_SEND);
    done_d    = (state_d == ST_DONE);
  end

  assign bit_out     = bit_out_q;
  assign bit_strobe  = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prsnt_state = state_q;

endmodule
